// File: rtl/pll_lock_mgr_if.sv
// Signal bundle between the PLL lock manager and the PLL / reset-consumer side.
// The master modport is the manager; the slave modport is the PLL and stimulus side.
interface pll_lock_mgr_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
);
  logic              pll_lock;
  logic              relock_req;
  logic              pll_reset;
  logic [NUM_CH-1:0] rst_out_n;
  logic              locked;
  logic              fault;
  logic [2:0]        state;
  logic [CNT_W-1:0]  relock_cnt;

  modport master (
    input  pll_lock, relock_req,
    output pll_reset, rst_out_n, locked, fault, state, relock_cnt
  );

  modport slave (
    output pll_lock, relock_req,
    input  pll_reset, rst_out_n, locked, fault, state, relock_cnt
  );
endinterface

// File: rtl/pll_lock_mgr.sv
// PLL supervisor: pulses PLL reset, debounces lock with timeout and bounded retries,
// releases NUM_CH downstream resets in a staggered order and re-acquires on lock loss.
//
// state      | meaning
// IDLE       | one cycle after reset release
// PLL_RST    | pll_reset held high for RST_PULSE cycles
// WAIT_LOCK  | waiting for LOCK_STABLE continuous lock_s cycles, bounded by LOCK_TIMEOUT
// RELEASE    | channel resets released one by one, REL_STAGGER apart
// RUN        | locked, all channels out of reset
// FAULT      | retries exhausted, PLL held in reset until relock_req
module pll_lock_mgr #(
  parameter int NUM_CH       = 4,
  parameter int RST_PULSE    = 16,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 65536,
  parameter int REL_STAGGER  = 8,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 8
) (
  input  logic            clkin,
  input  logic            reset_n,
  pll_lock_mgr_if.master  bus
);

  localparam int REL_LAST = (NUM_CH - 1) * REL_STAGGER;
  localparam int PUL_W    = $clog2(RST_PULSE + 1);
  localparam int STB_W    = $clog2(LOCK_STABLE + 1);
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int REL_W    = $clog2(REL_LAST + 2);
  localparam int RTY_W    = $clog2(MAX_RETRY + 1);

  localparam logic [PUL_W-1:0] PUL_LAST = PUL_W'(RST_PULSE - 1);
  localparam logic [STB_W-1:0] STB_LAST = STB_W'(LOCK_STABLE - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
  localparam logic [REL_W-1:0] REL_END  = REL_W'(REL_LAST);
  localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLL_RST   = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAULT     = 3'd5
  } state_t;

  logic              r_lock_meta;
  logic              r_lock_s;
  state_t            r_state;
  logic [PUL_W-1:0]  r_pul_cnt;
  logic [STB_W-1:0]  r_stb_cnt;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic [REL_W-1:0]  r_rel_cnt;
  logic [RTY_W-1:0]  r_retry;
  logic              r_pll_reset;
  logic [NUM_CH-1:0] r_rst_out_n;
  logic              r_locked;
  logic              r_fault;
  logic [CNT_W-1:0]  r_relock_cnt;

  logic              w_req;
  logic              w_lock_lost;
  logic [RTY_W-1:0]  w_retry_inc;
  logic [CNT_W-1:0]  w_relock_sat;
  logic [31:0]       w_k_next;
  logic [NUM_CH-1:0] w_rel_mask;

  assign w_req = bus.relock_req &&
                 (r_state == ST_WAIT_LOCK || r_state == ST_RELEASE ||
                  r_state == ST_RUN       || r_state == ST_FAULT);
  assign w_lock_lost  = !r_lock_s && (r_state == ST_RELEASE || r_state == ST_RUN);
  assign w_retry_inc  = r_retry + RTY_W'(1);
  assign w_relock_sat = (r_relock_cnt == {CNT_W{1'b1}}) ? r_relock_cnt
                                                       : r_relock_cnt + CNT_W'(1);
  assign w_k_next     = 32'(r_rel_cnt) + 32'd1;

  // Channels whose release slot is at or before the next RELEASE cycle.
  always_comb begin
    w_rel_mask = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_rel_mask[i] = ($unsigned(i * REL_STAGGER) <= w_k_next);
    end
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      r_lock_meta  <= 1'b0;
      r_lock_s     <= 1'b0;
      r_state      <= ST_IDLE;
      r_pul_cnt    <= '0;
      r_stb_cnt    <= '0;
      r_tmo_cnt    <= '0;
      r_rel_cnt    <= '0;
      r_retry      <= '0;
      r_pll_reset  <= 1'b1;
      r_rst_out_n  <= '0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_relock_cnt <= '0;
    end else begin
      r_lock_meta <= bus.pll_lock;
      r_lock_s    <= r_lock_meta;

      if (w_req) begin
        // An explicit request outranks a simultaneous lock loss and is not counted.
        r_state     <= ST_PLL_RST;
        r_pul_cnt   <= '0;
        r_retry     <= '0;
        r_pll_reset <= 1'b1;
        r_rst_out_n <= '0;
        r_locked    <= 1'b0;
        r_fault     <= 1'b0;
      end else if (w_lock_lost) begin
        r_relock_cnt <= w_relock_sat;
        r_rst_out_n  <= '0;
        r_locked     <= 1'b0;
        r_pll_reset  <= 1'b1;
        r_pul_cnt    <= '0;
        if (r_state == ST_RELEASE) begin
          r_retry <= w_retry_inc;
          if (w_retry_inc == RTY_MAX) begin
            r_state <= ST_FAULT;
            r_fault <= 1'b1;
          end else begin
            r_state <= ST_PLL_RST;
          end
        end else begin
          r_state <= ST_PLL_RST;
        end
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state     <= ST_PLL_RST;
            r_pul_cnt   <= '0;
            r_pll_reset <= 1'b1;
          end
          ST_PLL_RST: begin
            if (bus.relock_req) begin
              r_pul_cnt <= '0;
            end else if (r_pul_cnt == PUL_LAST) begin
              r_state     <= ST_WAIT_LOCK;
              r_pll_reset <= 1'b0;
              r_stb_cnt   <= '0;
              r_tmo_cnt   <= '0;
            end else begin
              r_pul_cnt <= r_pul_cnt + PUL_W'(1);
            end
          end
          ST_WAIT_LOCK: begin
            // Stable completion is tested first so it wins a tie with the timeout.
            if (r_lock_s && r_stb_cnt == STB_LAST) begin
              r_state     <= ST_RELEASE;
              r_retry     <= '0;
              r_rel_cnt   <= '0;
              r_rst_out_n <= NUM_CH'(1);
            end else if (r_tmo_cnt == TMO_LAST) begin
              r_pll_reset <= 1'b1;
              r_pul_cnt   <= '0;
              r_retry     <= w_retry_inc;
              if (w_retry_inc == RTY_MAX) begin
                r_state <= ST_FAULT;
                r_fault <= 1'b1;
              end else begin
                r_state <= ST_PLL_RST;
              end
            end else begin
              r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
              r_stb_cnt <= r_lock_s ? r_stb_cnt + STB_W'(1) : '0;
            end
          end
          ST_RELEASE: begin
            if (r_rel_cnt == REL_END) begin
              r_state     <= ST_RUN;
              r_locked    <= 1'b1;
              r_rst_out_n <= '1;
            end else begin
              r_rel_cnt   <= r_rel_cnt + REL_W'(1);
              r_rst_out_n <= r_rst_out_n | w_rel_mask;
            end
          end
          ST_RUN: begin
            r_locked <= 1'b1;
          end
          ST_FAULT: begin
            r_pll_reset <= 1'b1;
            r_fault     <= 1'b1;
          end
          default: begin
            r_state     <= ST_IDLE;
            r_pll_reset <= 1'b1;
            r_rst_out_n <= '0;
            r_locked    <= 1'b0;
            r_fault     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pll_reset  = r_pll_reset;
  assign bus.rst_out_n  = r_rst_out_n;
  assign bus.locked     = r_locked;
  assign bus.fault      = r_fault;
  assign bus.state      = r_state;
  assign bus.relock_cnt = r_relock_cnt;

endmodule

// File: tb/tb_pll_lock_mgr.sv
// Bench for pll_lock_mgr: stimulus pushes time-stamped expected outputs to a queue;
// a negedge monitor pops each entry in its cycle and compares against the DUT.
module tb_pll_lock_mgr;

  localparam int F_ST  = 0;
  localparam int F_PR  = 1;
  localparam int F_RST = 2;
  localparam int F_LK  = 3;
  localparam int F_FLT = 4;
  localparam int F_CNT = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
    int          at;
  } sb_t;

  logic  clkin;
  logic  reset_n;
  int    cyc;
  int    n_checks;
  int    n_errs;
  int    exp_cnt;
  logic  drain_req;
  logic  drain_done;
  sb_t   sb_q[$];
  sb_t   cur;
  string fnames [6] = '{"state", "pll_reset", "rst_out_n", "locked", "fault", "relock_cnt"};

  pll_lock_mgr_if #(.NUM_CH(4), .CNT_W(4)) ifc ();

  pll_lock_mgr #(
    .NUM_CH(4), .RST_PULSE(4), .LOCK_STABLE(8), .LOCK_TIMEOUT(64),
    .REL_STAGGER(2), .MAX_RETRY(2), .CNT_W(4)
  ) dut (
    .clkin  (clkin),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial cyc = 0;
  always @(posedge clkin) cyc <= cyc + 1;

  function automatic logic [31:0] fld(input int sel);
    case (sel)
      F_ST:    return 32'(ifc.state);
      F_PR:    return 32'(ifc.pll_reset);
      F_RST:   return 32'(ifc.rst_out_n);
      F_LK:    return 32'(ifc.locked);
      F_FLT:   return 32'(ifc.fault);
      default: return 32'(ifc.relock_cnt);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  always @(negedge clkin) begin
    while (sb_q.size() > 0 && sb_q[0].at <= cyc) begin
      cur = sb_q.pop_front();
      chk($sformatf("%s.%s", cur.tag, fnames[cur.sel]), fld(cur.sel), cur.exp);
    end
    if (drain_req && !drain_done) begin
      chk("sb_drain", 32'(sb_q.size()), 32'd0);
      drain_done = 1'b1;
    end
  end

  task automatic push(input string tag, input int sel, input int exp_v, input int at);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = 32'(exp_v);
    e.at  = at;
    sb_q.push_back(e);
  endtask

  task automatic push_outs(input string tag, input int at, input int st, input int pr,
                           input int rst, input int lk, input int flt);
    push(tag, F_ST, st, at);
    push(tag, F_PR, pr, at);
    push(tag, F_RST, rst, at);
    push(tag, F_LK, lk, at);
    push(tag, F_FLT, flt, at);
  endtask

  // RELEASE entered at cycle r: bit i rises at r + 2*i, RUN at r + 7.
  task automatic push_release(input string tag, input int r);
    push(tag, F_ST, 2, r - 1);
    push(tag, F_ST, 3, r);
    push(tag, F_RST, 1, r);
    push(tag, F_RST, 1, r + 1);
    push(tag, F_RST, 3, r + 2);
    push(tag, F_RST, 7, r + 4);
    push(tag, F_RST, 15, r + 6);
    push(tag, F_LK, 0, r + 6);
    push(tag, F_ST, 4, r + 7);
    push(tag, F_LK, 1, r + 7);
  endtask

  // WAIT_LOCK entered at w with lock_s already high: release after 8 stable cycles.
  task automatic push_relock(input string tag, input int w);
    push(tag, F_ST, 2, w);
    push(tag, F_PR, 0, w);
    push_release(tag, w + 8);
  endtask

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  task automatic tick_to(input int c);
    while (cyc < c) tick();
  endtask

  initial begin
    int d, w, w2, f, w3, r, g;
    n_checks       = 0;
    n_errs         = 0;
    exp_cnt        = 0;
    drain_req      = 1'b0;
    drain_done     = 1'b0;
    reset_n        = 1'b1;
    ifc.pll_lock   = 1'b0;
    ifc.relock_req = 1'b0;
    #1 reset_n = 1'b0;

    // Reset values, IDLE for one cycle, 4-cycle PLL reset pulse, clean lock.
    push_outs("reset", 2, 0, 1, 0, 0, 0);
    push("reset", F_CNT, 0, 2);
    push("idle", F_ST, 0, 3);
    push_outs("pll_rst", 4, 1, 1, 0, 0, 0);
    push("pll_rst", F_PR, 1, 7);
    push("wait", F_ST, 2, 8);
    push("wait", F_PR, 0, 8);
    push_release("clean", 28);
    tick_to(3);
    reset_n = 1'b1;
    tick_to(18);
    ifc.pll_lock = 1'b1;
    tick_to(36);

    // relock_req coincident with lock_s falling in RUN, then a request inside PLL_RST.
    push("conc", F_ST, 4, 40);
    push_outs("conc_req", 41, 1, 1, 0, 0, 0);
    push("conc_req", F_CNT, 0, 41);
    push("ext", F_PR, 1, 46);
    push("ext", F_ST, 1, 46);
    push_relock("ext_relock", 47);
    tick_to(38);
    ifc.pll_lock = 1'b0;
    tick_to(40);
    ifc.relock_req = 1'b1;
    tick_to(41);
    ifc.relock_req = 1'b0;
    ifc.pll_lock   = 1'b1;
    tick_to(42);
    ifc.relock_req = 1'b1;
    tick_to(43);
    ifc.relock_req = 1'b0;
    tick_to(63);

    // Single-cycle lock drops in RUN, repeated until relock_cnt saturates.
    for (int n = 0; n < 20; n++) begin
      d = cyc + 2;
      exp_cnt = (exp_cnt == 15) ? 15 : exp_cnt + 1;
      push("loss_run", F_ST, 4, d + 2);
      push_outs("loss", d + 3, 1, 1, 0, 0, 0);
      push("loss", F_CNT, exp_cnt, d + 3);
      push_relock("loss_relock", d + 7);
      tick_to(d);
      ifc.pll_lock = 1'b0;
      tick_to(d + 1);
      ifc.pll_lock = 1'b1;
      tick_to(d + 23);
    end

    // Glitchy lock: 5 high, 1 low, then high; stable count restarts.
    d = cyc + 2;
    w = d + 7;
    g = w + 5;
    push_outs("glitch_loss", d + 3, 1, 1, 0, 0, 0);
    push("glitch_loss", F_CNT, 15, d + 3);
    push("glitch_wait", F_ST, 2, w);
    push("glitch_wait", F_ST, 2, g + 10);
    push_release("glitch", g + 16);
    tick_to(d);
    ifc.pll_lock = 1'b0;
    tick_to(g);
    ifc.pll_lock = 1'b1;
    tick_to(g + 5);
    ifc.pll_lock = 1'b0;
    tick_to(g + 6);
    ifc.pll_lock = 1'b1;
    tick_to(g + 24);

    // Two timeouts into FAULT, relock_req out of FAULT clears the retry count.
    d  = cyc + 2;
    w  = d + 7;
    w2 = w + 68;
    f  = w2 + 72;
    w3 = f + 73;
    r  = w3 + 10;
    push_outs("to_loss", d + 3, 1, 1, 0, 0, 0);
    push("to_wait", F_ST, 2, w);
    push("to_wait", F_PR, 0, w);
    push("to_wait", F_ST, 2, w + 63);
    push_outs("to1", w + 64, 1, 1, 0, 0, 0);
    push("to1", F_PR, 1, w + 67);
    push("to_wait2", F_ST, 2, w2);
    push("to_wait2", F_PR, 0, w2);
    push("to_wait2", F_ST, 2, w2 + 63);
    push_outs("fault", w2 + 64, 5, 1, 0, 0, 1);
    push_outs("fault_hold", w2 + 70, 5, 1, 0, 0, 1);
    push_outs("fault_req", f + 1, 1, 1, 0, 0, 0);
    push("retry_clr", F_ST, 2, f + 5);
    push("retry_clr", F_ST, 2, f + 68);
    push("retry_clr", F_ST, 1, f + 69);
    push("midrel_wait", F_ST, 2, w3);
    push("midrel_wait", F_PR, 0, w3);
    push("midrel", F_ST, 2, r - 1);
    push("midrel", F_ST, 3, r);
    push("midrel", F_RST, 1, r);
    push("midrel", F_RST, 1, r + 1);
    tick_to(d);
    ifc.pll_lock = 1'b0;
    tick_to(f);
    ifc.relock_req = 1'b1;
    tick_to(f + 1);
    ifc.relock_req = 1'b0;
    tick_to(w3);
    ifc.pll_lock = 1'b1;

    // Reset asserted while rst_out_n=0011; values must change before the next edge.
    tick_to(r + 2);
    reset_n = 1'b0;
    push_outs("midrel_rst", r + 2, 0, 1, 0, 0, 0);
    push("midrel_rst", F_CNT, 0, r + 2);
    tick_to(r + 4);
    reset_n = 1'b1;
    push("post_rst_idle", F_ST, 0, r + 4);
    push_outs("post_rst_pll", r + 5, 1, 1, 0, 0, 0);
    push_relock("post_rst_relock", r + 9);
    tick_to(r + 9 + 16);

    for (int i = 0; i < 50 && sb_q.size() > 0; i++) tick();
    drain_req = 1'b1;
    for (int i = 0; i < 4 && !drain_done; i++) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
